com_interface: RTL and testbench
================================

COM_INTERFACE -- requirements
Module: com_interface

Interface
REQ-001 SHALL have parameter AUDIO_ADDR, default 16'h7F00; the memory-mapped address of the sound register port.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, and all logic is rising-edge.
REQ-003 SHALL have port reset_n, input, 1 bit; the reset, which is asynchronous and active-low.
REQ-004 SHALL have port addr, input, 16 bits; the CPU address bus.
REQ-005 SHALL have port data, input, 8 bits; the CPU write data.
REQ-006 SHALL have port MREQ_N, input, 1 bit; the active-low memory request.
REQ-007 SHALL have port WR_N, input, 1 bit; the active-low write strobe.
REQ-008 SHALL have port freq, output, 10 bits; the tone period of the most recently updated tone channel.
REQ-009 SHALL have port waveform_valid, output, 1 bit; a one-cycle pulse marking a freq update.
REQ-010 SHALL have port enable, output, 3 bits; a one-hot tone channel select, valid with waveform_valid.
REQ-011 SHALL have port atten_mag, output, 4 bits; the attenuation of the most recently updated channel, where 0 is loudest and F is off.
REQ-012 SHALL have port atten_enable, output, 3 bits; a one-hot attenuation channel select pulse.

Function
REQ-013 SHALL treat all bus inputs as synchronous to clk.
REQ-014 SHALL detect a write on the first clk cycle in which MREQ_N=0, WR_N=0 and addr==AUDIO_ADDR, and SHALL sample data in that cycle.
REQ-015 SHALL accept no further write until MREQ_N or WR_N returns high; a strobe held low for N cycles yields exactly one write.
REQ-016 SHALL ignore reads (WR_N=1) and non-matching addresses.
REQ-017 SHALL decode a latch byte (data[7]=1) as: ch=data[6:5], type=data[4] (0=tone, 1=atten), value=data[3:0]; ch and type are stored as the latched register.
REQ-018 On a latch tone write, SHALL store value into tone[ch][3:0].
REQ-019 On a latch atten write to ch 0-2, SHALL set atten_mag=value and pulse atten_enable bit ch.
REQ-020 On a data byte (data[7]=0) with latched tone ch 0-2, SHALL set tone[ch][9:4]=data[5:0], drive freq=tone[ch], pulse enable bit ch and pulse waveform_valid.
REQ-021 On a data byte with latched atten, SHALL set atten_mag=data[3:0] and pulse atten_enable bit ch.
REQ-022 SHALL store but not output ch=3 (noise) writes: no strobes, and freq/atten_mag unchanged.
REQ-023 SHALL assert every output pulse for exactly one clk, in the cycle after the write-detect cycle (latency 1).
REQ-024 SHALL register freq and atten_mag, holding them between updates.
REQ-025 SHALL never set more than one bit in enable or atten_enable.

Reset
REQ-026 While reset_n=0, SHALL force freq=0, atten_mag=4'hF, waveform_valid=0, enable=0 and atten_enable=0.
REQ-027 While reset_n=0, SHALL clear all tone registers to 0, set latched ch=0 and type=tone, and clear the write-detect state.
REQ-028 A reset asserted mid-write SHALL discard that write; a strobe still low at reset release SHALL NOT count as a new write.

Configuration
REQ-029 With COM_IMMEDIATE_TONE_EN defined, a latch tone write to ch 0-2 SHALL also drive freq=tone[ch] with the new low nibble, pulse enable and pulse waveform_valid.
REQ-030 Without COM_IMMEDIATE_TONE_EN, freq SHALL update only on data bytes.

Structure
REQ-031 Package com_pkg SHALL hold the channel-type enum (TONE, ATTEN), the channel index type, the AUDIO_ADDR default and ATTEN_OFF=4'hF.
REQ-032 Sub-module bus_write_detect (address match plus single-shot write edge) SHALL be instantiated once.

Verification
REQ-033 Reset check: hold reset_n=0 -> freq=0, atten_mag=F, all strobes 0.
REQ-034 Tone write: write 0x8E then 0x0F to 7F00 -> freq=0x0FE, enable=001, waveform_valid high for 1 cycle, one cycle after the second write (without the macro).
REQ-035 Atten write: write 0xDA -> atten_mag=A, atten_enable=100 for 1 cycle; then write 0x03 -> atten_mag=3, atten_enable=100.
REQ-036 Filtering: write 0x8E to addr 1234, then a read of 7F00, then a write of 0xE5 (noise) -> no strobes, outputs unchanged.
REQ-037 Long strobe: MREQ_N/WR_N held low 5 cycles with data 0x25 after latch 0xA0 -> exactly one waveform_valid, freq=0x250, enable=010.
REQ-038 Macro: with COM_IMMEDIATE_TONE_EN, write 0xA7 -> waveform_valid pulse, freq low nibble=7, enable=010.

Source files
------------

// File: rtl/com_pkg.sv
// Shared types and constants for the sound-chip register port.
// Latency: n/a. Backpressure: n/a.
package com_pkg;

    typedef enum logic {
        TONE  = 1'b0,
        ATTEN = 1'b1
    } ch_type_t;

    typedef logic [1:0] ch_idx_t;

    localparam logic [15:0] AUDIO_ADDR_DEFAULT = 16'h7F00;
    localparam logic [3:0]  ATTEN_OFF          = 4'hF;
    localparam ch_idx_t     NOISE_CH           = 2'd3;

    // One-hot select for tone channels 0-2; the noise channel maps to no strobe.
    function automatic logic [2:0] ch_onehot(input ch_idx_t ch);
        logic [2:0] sel;
        sel = 3'b000;
        if (ch != NOISE_CH)
            sel[ch] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/bus_write_detect.sv
// Address match plus single-shot write detect on a synchronous CPU bus strobe.
// Latency: combinational pulse in the first matching strobe cycle. Backpressure: none.
// Re-arms only once MREQ_N or WR_N goes high, so a long strobe gives one write.
module bus_write_detect #(
    parameter logic [15:0] MATCH_ADDR = 16'h7F00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic        MREQ_N,
    input  logic        WR_N,
    output logic        wr_det
);

    logic armed;
    logic strobe_low;

    assign strobe_low = !MREQ_N && !WR_N;
    assign wr_det     = armed && strobe_low && (addr == MATCH_ADDR);

    // Reset leaves the detector disarmed so a strobe still low at release is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            armed <= 1'b0;
        else if (!strobe_low)
            armed <= 1'b1;
        else if (wr_det)
            armed <= 1'b0;
    end

endmodule

// File: rtl/com_interface.sv
// CPU-bus to sound-generator register interface (latch/data byte protocol, 3 tone + noise).
// Latency: 1 clk from write detect to registered outputs/pulses. Backpressure: none, every write accepted.
// COM_IMMEDIATE_TONE_EN: a latch tone byte also updates freq and pulses enable/waveform_valid.
module com_interface
    import com_pkg::*;
#(
    parameter logic [15:0] AUDIO_ADDR = AUDIO_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    input  logic        MREQ_N,
    input  logic        WR_N,
    output logic [9:0]  freq,
    output logic        waveform_valid,
    output logic [2:0]  enable,
    output logic [3:0]  atten_mag,
    output logic [2:0]  atten_enable
);

    logic       wr_det;
    logic [9:0] tone [4];
    ch_idx_t    lat_ch;
    ch_type_t   lat_type;
    ch_idx_t    byte_ch;
    ch_type_t   byte_type;

    assign byte_ch   = data[6:5];
    assign byte_type = ch_type_t'(data[4]);

    bus_write_detect #(
        .MATCH_ADDR (AUDIO_ADDR)
    ) u_bus_write_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .MREQ_N  (MREQ_N),
        .WR_N    (WR_N),
        .wr_det  (wr_det)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freq           <= '0;
            waveform_valid <= 1'b0;
            enable         <= '0;
            atten_mag      <= ATTEN_OFF;
            atten_enable   <= '0;
            lat_ch         <= '0;
            lat_type       <= TONE;
            for (int i = 0; i < 4; i++)
                tone[i] <= '0;
        end else begin
            waveform_valid <= 1'b0;
            enable         <= '0;
            atten_enable   <= '0;
            if (wr_det) begin
                if (data[7]) begin
                    lat_ch   <= byte_ch;
                    lat_type <= byte_type;
                    if (byte_type == TONE) begin
                        tone[byte_ch][3:0] <= data[3:0];
`ifdef COM_IMMEDIATE_TONE_EN
                        if (byte_ch != NOISE_CH) begin
                            freq           <= {tone[byte_ch][9:4], data[3:0]};
                            enable         <= ch_onehot(byte_ch);
                            waveform_valid <= 1'b1;
                        end
`endif
                    end else if (byte_ch != NOISE_CH) begin
                        atten_mag    <= data[3:0];
                        atten_enable <= ch_onehot(byte_ch);
                    end
                end else if (lat_type == TONE) begin
                    tone[lat_ch][9:4] <= data[5:0];
                    if (lat_ch != NOISE_CH) begin
                        freq           <= {data[5:0], tone[lat_ch][3:0]};
                        enable         <= ch_onehot(lat_ch);
                        waveform_valid <= 1'b1;
                    end
                end else if (lat_ch != NOISE_CH) begin
                    atten_mag    <= data[3:0];
                    atten_enable <= ch_onehot(lat_ch);
                end
            end
        end
    end

endmodule

// File: tb/tb_com_interface.sv
// Directed-vector bench for com_interface: reset, tone/atten writes, filtering, long strobe, reset mid-write.
module tb_com_interface;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        MREQ_N;
    logic        WR_N;
    logic [9:0]  freq;
    logic        waveform_valid;
    logic [2:0]  enable;
    logic [3:0]  atten_mag;
    logic [2:0]  atten_enable;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int wv_cnt   = 0;
    int aen_cnt  = 0;
    logic [2:0] last_en = '0;

    com_interface #(
        .AUDIO_ADDR (16'h7F00)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .addr           (addr),
        .data           (data),
        .MREQ_N         (MREQ_N),
        .WR_N           (WR_N),
        .freq           (freq),
        .waveform_valid (waveform_valid),
        .enable         (enable),
        .atten_mag      (atten_mag),
        .atten_enable   (atten_enable)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (waveform_valid) begin
            wv_cnt++;
            last_en = enable;
        end
        if (atten_enable != 3'b000)
            aen_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle from a falling edge; returns on the falling edge where strobe is released.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic wr, input int hold);
        @(negedge clk);
        addr   = a;
        data   = d;
        MREQ_N = 1'b0;
        WR_N   = !wr;
        repeat (hold) @(negedge clk);
        MREQ_N = 1'b1;
        WR_N   = 1'b1;
        data   = 8'($urandom_range(0, 255));
    endtask

    initial begin
        reset_n = 1'b0;
        addr    = 16'h0000;
        data    = 8'h00;
        MREQ_N  = 1'b1;
        WR_N    = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_freq", 16'(freq), 16'h000);
        check("rst_atten", 16'(atten_mag), 16'hF);
        check("rst_wv", 16'(waveform_valid), 16'h0);
        check("rst_en", 16'(enable), 16'h0);
        check("rst_aen", 16'(atten_enable), 16'h0);

        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tone: latch ch0 low nibble E, then data 0x0F -> 0x0FE
        bus_cycle(16'h7F00, 8'h8E, 1'b1, 1);
`ifndef COM_IMMEDIATE_TONE_EN
        check("latch_no_wv", 16'(waveform_valid), 16'h0);
`endif
        bus_cycle(16'h7F00, 8'h0F, 1'b1, 1);
        check("tone_freq", 16'(freq), 16'h0FE);
        check("tone_en", 16'(enable), 16'h1);
        check("tone_wv", 16'(waveform_valid), 16'h1);
        @(negedge clk);
        check("tone_wv_end", 16'(waveform_valid), 16'h0);
        check("tone_en_end", 16'(enable), 16'h0);
        check("tone_hold", 16'(freq), 16'h0FE);

        // Atten: latch ch2 atten A, then data 3
        bus_cycle(16'h7F00, 8'hDA, 1'b1, 1);
        check("att_latch_mag", 16'(atten_mag), 16'hA);
        check("att_latch_aen", 16'(atten_enable), 16'h4);
        @(negedge clk);
        check("att_aen_end", 16'(atten_enable), 16'h0);
        bus_cycle(16'h7F00, 8'h03, 1'b1, 1);
        check("att_data_mag", 16'(atten_mag), 16'h3);
        check("att_data_aen", 16'(atten_enable), 16'h4);

        // Filtering: wrong address, read, and noise channel writes
        @(negedge clk);
        wv_cnt  = 0;
        aen_cnt = 0;
        bus_cycle(16'h1234, 8'h8E, 1'b1, 1);
        bus_cycle(16'h7F00, 8'h9C, 1'b0, 1);
        bus_cycle(16'h7F00, 8'hE5, 1'b1, 1);
        bus_cycle(16'h7F00, 8'h3F, 1'b1, 1);
        repeat (2) @(negedge clk);
        check("filt_wv_cnt", 16'(wv_cnt), 16'd0);
        check("filt_aen_cnt", 16'(aen_cnt), 16'd0);
        check("filt_freq", 16'(freq), 16'h0FE);
        check("filt_atten", 16'(atten_mag), 16'h3);

        // Long strobe: latch ch1 tone 0, data 0x25 held 5 cycles -> one pulse
        bus_cycle(16'h7F00, 8'hA0, 1'b1, 1);
        repeat (2) @(negedge clk);
        wv_cnt = 0;
        bus_cycle(16'h7F00, 8'h25, 1'b1, 5);
        repeat (2) @(negedge clk);
        check("long_wv_cnt", 16'(wv_cnt), 16'd1);
        check("long_freq", 16'(freq), 16'h250);
        check("long_en", 16'(last_en), 16'h2);

        // Reset asserted mid-write, strobe still low at release
        wv_cnt = 0;
        @(negedge clk);
        addr    = 16'h7F00;
        data    = 8'h05;
        MREQ_N  = 1'b0;
        WR_N    = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        MREQ_N = 1'b1;
        WR_N   = 1'b1;
        @(negedge clk);
        check("rstmid_wv_cnt", 16'(wv_cnt), 16'd0);
        check("rstmid_freq", 16'(freq), 16'h000);
        check("rstmid_atten", 16'(atten_mag), 16'hF);

        // After reset the latched register is tone ch0 with cleared tones
        bus_cycle(16'h7F00, 8'h01, 1'b1, 1);
        check("post_rst_freq", 16'(freq), 16'h010);
        check("post_rst_en", 16'(enable), 16'h1);

`ifdef COM_IMMEDIATE_TONE_EN
        bus_cycle(16'h7F00, 8'hA7, 1'b1, 1);
        check("imm_wv", 16'(waveform_valid), 16'h1);
        check("imm_freq", 16'(freq), 16'h007);
        check("imm_en", 16'(enable), 16'h2);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
